// File: rtl/snn_pkt_pkg.sv
// Shared packet format, opcodes, accumulator width and SPE state type for the
// spiking network router endpoints.
package snn_pkt_pkg;

  localparam int PKT_W     = 33;
  localparam int ADDR_HI   = 32;
  localparam int ADDR_LO   = 29;
  localparam int OPCODE_HI = 28;
  localparam int OPCODE_LO = 25;
  localparam int DATA_HI   = 24;
  localparam int DATA_LO   = 0;

  // Width of membrane potential / partial-sum accumulator.
  localparam int SUM_WIDTH = 13;

  localparam logic [3:0] OP_PSUM          = 4'd2;
  localparam logic [3:0] OP_RESIDUAL      = 4'd0;
  localparam logic [3:0] OP_TIMESTEP_DONE = 4'd15;

  // Store (spike + residual) opcode an SPE sends to omem.
  function automatic logic [3:0] op_spe_send(input int id);
    return 4'(2 * id);
  endfunction

  // Residual fetch opcode an SPE sends to omem.
  function automatic logic [3:0] op_spe_req(input int id);
    return 4'(2 * id + 1);
  endfunction

  typedef enum logic [2:0] {
    ST_ACCUM    = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_FIRE     = 3'd3,
    ST_SEND     = 3'd4,
    ST_WAIT_TS  = 3'd5,
    ST_DONE     = 3'd6
  } spe_state_e;

endpackage

// File: rtl/spe_sat_add.sv
// Unsigned saturating adder: clamps to all-ones on overflow and flags it.
module spe_sat_add #(
  parameter int W = 13
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  logic [W:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};
  assign sat = raw[W];
  assign sum = raw[W] ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/spe_neuron.sv
// Spiking processing element: accumulates partial sums for each owned output
// neuron, fetches the stored residual in timestep 2, thresholds, and sends a
// spike/residual store packet to omem.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// out_valid/out_packet are registered and held until accepted. in_ready is a
// combinational function of state and the incoming opcode; an unexpected
// opcode is stalled (in_ready=0), never dropped.
module spe_neuron
  import snn_pkt_pkg::*;
#(
  parameter int SPE_ID      = 0,
  parameter int OMEM_ID     = 11,
  parameter int OUTPUT_SIZE = 21,
  parameter int NUM_PSUMS   = 5,
  parameter int THRESHOLD   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] in_packet,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] out_packet,
  output logic [1:0]  ts_o,
  output logic        done_o,
  output logic        sat_o,
  output logic [2:0]  state_o
);

  localparam int NUM_NEURONS = OUTPUT_SIZE * OUTPUT_SIZE;
  localparam int IDX_W       = $clog2(NUM_NEURONS + 5) + 1;
  localparam int CNT_W       = $clog2(NUM_PSUMS + 1);

  localparam logic [IDX_W-1:0]     IDX_START = IDX_W'(SPE_ID);
  localparam logic [IDX_W-1:0]     IDX_END   = IDX_W'(NUM_NEURONS);
  localparam logic [IDX_W-1:0]     IDX_STEP  = IDX_W'(5);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(NUM_PSUMS - 1);
  localparam logic [SUM_WIDTH-1:0] THR       = SUM_WIDTH'(THRESHOLD);
  localparam logic [3:0]           OMEM_ADDR = 4'(OMEM_ID);
  localparam logic [3:0]           SEND_OP   = op_spe_send(SPE_ID);
  localparam logic [3:0]           REQ_OP    = op_spe_req(SPE_ID);

  spe_state_e           state, state_n;
  logic [SUM_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     psum_cnt;
  logic [IDX_W-1:0]     neuron_idx;
  logic [IDX_W-1:0]     idx_next;
  logic                 ts2;

  logic [3:0]           in_opcode;
  logic [SUM_WIDTH-1:0] in_data;
  logic [SUM_WIDTH-1:0] sum;
  logic                 sum_sat;
  logic                 accept_in;
  logic                 accept_out;
  logic                 spike;
  logic [SUM_WIDTH-1:0] pot;
  logic                 unused_in_bits;

  assign in_opcode      = in_packet[OPCODE_HI:OPCODE_LO];
  assign in_data        = in_packet[SUM_WIDTH-1:0];
  assign unused_in_bits = ^{in_packet[ADDR_HI:ADDR_LO], in_packet[DATA_HI:SUM_WIDTH]};

  // Only the opcode that the current state is waiting for is let through.
  assign in_ready = !reset &&
                    (((state == ST_ACCUM)    && (in_opcode == OP_PSUM))     ||
                     ((state == ST_WAIT_RES) && (in_opcode == OP_RESIDUAL)) ||
                     ((state == ST_WAIT_TS)  && (in_opcode == OP_TIMESTEP_DONE)));

  assign accept_in  = in_valid && in_ready;
  assign accept_out = out_valid && out_ready;
  assign idx_next   = neuron_idx + IDX_STEP;

  assign spike = (acc >= THR);
  assign pot   = spike ? (acc - THR) : acc;

  assign ts_o    = ts2 ? 2'd2 : 2'd1;
  assign done_o  = (state == ST_DONE);
  assign state_o = state;

  // Psums and residuals share one saturating adder; they are never accepted together.
  spe_sat_add #(.W(SUM_WIDTH)) u_sat_add (
    .a   (acc),
    .b   (in_data),
    .sum (sum),
    .sat (sum_sat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_ACCUM;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_ACCUM: begin
        if (accept_in && (psum_cnt == CNT_LAST)) state_n = ts2 ? ST_REQ : ST_FIRE;
      end
      ST_REQ: begin
        if (accept_out) state_n = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (accept_in) state_n = ST_FIRE;
      end
      ST_FIRE: begin
        state_n = ST_SEND;
      end
      ST_SEND: begin
        if (accept_out) begin
          if (idx_next >= IDX_END) state_n = ts2 ? ST_DONE : ST_WAIT_TS;
          else                     state_n = ST_ACCUM;
        end
      end
      ST_WAIT_TS: begin
        if (accept_in) state_n = ST_ACCUM;
      end
      ST_DONE: begin
        state_n = ST_DONE;
      end
      default: begin
        state_n = ST_ACCUM;
      end
    endcase
  end

  // Accumulator, neuron bookkeeping and the registered outgoing packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      psum_cnt   <= '0;
      neuron_idx <= IDX_START;
      ts2        <= 1'b0;
      sat_o      <= 1'b0;
      out_valid  <= 1'b0;
      out_packet <= '0;
    end else begin
      if (accept_in && ((state == ST_ACCUM) || (state == ST_WAIT_RES))) begin
        acc   <= sum;
        sat_o <= sat_o | sum_sat;
      end
      if (accept_in && (state == ST_ACCUM)) psum_cnt <= psum_cnt + 1'b1;
      if (accept_in && (state == ST_WAIT_TS)) begin
        ts2        <= 1'b1;
        neuron_idx <= IDX_START;
      end
      if (accept_out && (state == ST_SEND)) begin
        acc        <= '0;
        psum_cnt   <= '0;
        neuron_idx <= idx_next;
      end
      if ((state == ST_ACCUM) && (state_n == ST_REQ)) out_packet <= {OMEM_ADDR, REQ_OP, 25'd0};
      if (state == ST_FIRE) out_packet <= {OMEM_ADDR, SEND_OP, 24'(pot), spike};
      out_valid <= (state_n == ST_REQ) || (state_n == ST_SEND);
    end
  end

endmodule

// File: tb/tb_spe_neuron.sv
// Directed + randomized bench for spe_neuron (SPE_ID=2) against a behavioural
// model of neuron ownership, saturating accumulation and thresholding.
module tb_spe_neuron;

  localparam int SPE_ID   = 2;
  localparam int OMEM     = 11;
  localparam int SIDE     = 21;
  localparam int THR      = 64;
  localparam int MAXV     = 8191;
  localparam int BUDGET   = 200;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_packet;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_packet;
  logic [1:0]  ts_o;
  logic        done_o;
  logic        sat_o;
  logic [2:0]  state_dbg;

  int   n_cmp;
  int   n_fail;
  int   n_own;
  logic exp_sat;
  logic [32:0] exp_q[$];

  spe_neuron #(.SPE_ID(SPE_ID), .OMEM_ID(OMEM), .OUTPUT_SIZE(SIDE), .NUM_PSUMS(5), .THRESHOLD(THR)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_packet  (in_packet),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_packet (out_packet),
    .ts_o       (ts_o),
    .done_o     (done_o),
    .sat_o      (sat_o),
    .state_o    (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [32:0] store_pkt(input int total);
    int acc, pot;
    int spike;
    acc   = (total > MAXV) ? MAXV : total;
    spike = (acc >= THR) ? 1 : 0;
    pot   = (spike == 1) ? acc - THR : acc;
    return {4'(OMEM), 4'(2 * SPE_ID), 25'(pot * 2 + spike)};
  endfunction

  function automatic logic [32:0] req_pkt();
    return {4'(OMEM), 4'(2 * SPE_ID + 1), 25'd0};
  endfunction

  function automatic int rand_val(input int small_max);
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, MAXV));
    return int'($urandom_range(0, small_max));
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_in(input logic [3:0] op, input int data, input logic v);
    in_packet = {4'd0, op, 25'(data)};
    in_valid  = v;
    #1;
  endtask

  task automatic push(input logic [3:0] op, input int data);
    int n;
    set_in(op, data, 1'b1);
    n = 0;
    while (!in_ready && n < BUDGET) begin
      step();
      n++;
    end
    if (n >= BUDGET) check("push_timeout", {32'd0, in_ready}, 33'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, optionally stalls, checks against the head of exp_q, accepts.
  task automatic pull(input string tag, input int max_stall);
    int n;
    logic [32:0] exp;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < BUDGET) begin
      step();
      n++;
    end
    if (n >= BUDGET) check({tag, "_timeout"}, {32'd0, out_valid}, 33'd1);
    repeat ($urandom_range(0, max_stall)) step();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'd0;
    check({tag, "_valid"}, {32'd0, out_valid}, 33'd1);
    check(tag, out_packet, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_neuron(input int ts);
    int total, p;
    total = 0;
    for (int k = 0; k < 5; k++) begin
      p = rand_val(30);
      total += p;
      push(4'd2, p);
    end
    if (ts == 2) begin
      exp_q.push_back(req_pkt());
      pull("req", 3);
      p = rand_val(60);
      total += p;
      push(4'd0, p);
    end
    if (total > MAXV) exp_sat = 1'b1;
    exp_q.push_back(store_pkt(total));
    pull("store", 3);
  endtask

  // After the last owned neuron: ts1 must be waiting for timestep-done, ts2 must be done.
  task automatic finish_ts(input int ts);
    check("sat_o_end_ts", {32'd0, sat_o}, {32'd0, exp_sat});
    if (ts == 1) begin
      set_in(4'd2, 0, 1'b0);
      check("wait_ts_psum_stalled", {32'd0, in_ready}, 33'd0);
      set_in(4'd15, 0, 1'b0);
      check("wait_ts_ready", {32'd0, in_ready}, 33'd1);
      push(4'd15, 0);
      check("ts_o_after_ts_done", {31'd0, ts_o}, 33'd2);
    end else begin
      check("done_o", {32'd0, done_o}, 33'd1);
      check("done_out_valid", {32'd0, out_valid}, 33'd0);
      set_in(4'd2, 0, 1'b1);
      check("done_psum_stalled", {32'd0, in_ready}, 33'd0);
      set_in(4'd0, 0, 1'b1);
      step();
      check("done_residual_stalled", {32'd0, in_ready}, 33'd0);
      check("done_held", {32'd0, done_o}, 33'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    check("rst_out_valid", {32'd0, out_valid}, 33'd0);
    check("rst_ts_o", {31'd0, ts_o}, 33'd1);
    check("rst_done_o", {32'd0, done_o}, 33'd0);
    reset = 1'b0;
    exp_sat = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int total;
    n_cmp = 0; n_fail = 0; exp_sat = 1'b0;
    n_own = 0;
    for (int i = 0; i < SIDE * SIDE; i++) if (i % 5 == SPE_ID) n_own++;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_packet = {4'd0, 4'd2, 25'd0};
    repeat (3) step();
    check("rst_in_ready", {32'd0, in_ready}, 33'd0);
    check("rst_out_valid", {32'd0, out_valid}, 33'd0);
    check("rst_out_packet", out_packet, 33'd0);
    check("rst_ts_o", {31'd0, ts_o}, 33'd1);
    check("rst_done_o", {32'd0, done_o}, 33'd0);
    check("rst_sat_o", {32'd0, sat_o}, 33'd0);
    reset = 1'b0;
    #1;
    check("accum_ready_psum", {32'd0, in_ready}, 33'd1);
    set_in(4'd15, 0, 1'b0);
    check("accum_stall_ts_done", {32'd0, in_ready}, 33'd0);

    // Neuron 0: sum 70 -> spike with residual 6; valid two cycles after last accept.
    push(4'd2, 10); push(4'd2, 20); push(4'd2, 5); push(4'd2, 15); push(4'd2, 20);
    check("lat_fire_cycle", {32'd0, out_valid}, 33'd0);
    step();
    check("lat_valid", {32'd0, out_valid}, 33'd1);
    check("store_70", out_packet, store_pkt(70));
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Neuron 1: sum 30 -> no spike.
    for (int k = 0; k < 5; k++) push(4'd2, 6);
    exp_q.push_back(store_pkt(30));
    pull("store_30", 0);

    // Neuron 2: saturation.
    for (int k = 0; k < 5; k++) push(4'd2, 8000);
    exp_sat = 1'b1;
    exp_q.push_back(store_pkt(40000));
    check("store_sat_model", store_pkt(40000), {4'd11, 4'd4, 25'(8127 * 2 + 1)});
    pull("store_sat", 0);
    check("sat_o_set", {32'd0, sat_o}, 33'd1);

    // Neuron 3: long backpressure while a psum is offered.
    total = 0;
    for (int k = 0; k < 5; k++) begin
      int p;
      p = int'($urandom_range(0, 40));
      total += p;
      push(4'd2, p);
    end
    step();
    set_in(4'd2, 7, 1'b1);
    for (int c = 0; c < 10; c++) begin
      check("bp_out_valid", {32'd0, out_valid}, 33'd1);
      check("bp_out_packet", out_packet, store_pkt(total));
      check("bp_psum_stalled", {32'd0, in_ready}, 33'd0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1; step(); out_ready = 1'b0;

    for (int i = 4; i < n_own; i++) do_neuron(1);
    finish_ts(1);

    // Timestep 2, neuron 0: psums 40, residual 30.
    for (int k = 0; k < 5; k++) push(4'd2, 8);
    exp_q.push_back(req_pkt());
    pull("req_first", 2);
    set_in(4'd2, 5, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check("wait_res_psum_stalled", {32'd0, in_ready}, 33'd0);
      step();
    end
    push(4'd0, 30);
    check("ts2_lat_fire_cycle", {32'd0, out_valid}, 33'd0);
    step();
    check("ts2_lat_valid", {32'd0, out_valid}, 33'd1);
    check("ts2_store_70", out_packet, store_pkt(70));
    out_ready = 1'b1; step(); out_ready = 1'b0;

    for (int i = 1; i < n_own; i++) do_neuron(2);
    finish_ts(2);

    // Reset while a store packet is pending.
    do_reset();
    for (int k = 0; k < 5; k++) push(4'd2, 3);
    step();
    check("pending_valid", {32'd0, out_valid}, 33'd1);
    reset = 1'b1;
    step();
    check("drop_out_valid", {32'd0, out_valid}, 33'd0);
    check("drop_out_packet", out_packet, 33'd0);
    check("drop_sat_o", {32'd0, sat_o}, 33'd0);
    reset = 1'b0;
    exp_sat = 1'b0;

    // Reach WAIT_RES in timestep 2, then reset there.
    for (int i = 0; i < n_own; i++) do_neuron(1);
    finish_ts(1);
    for (int k = 0; k < 5; k++) push(4'd2, 1);
    exp_q.push_back(req_pkt());
    pull("req_before_reset", 1);
    do_reset();

    // Full clean two-timestep run after reset.
    for (int i = 0; i < n_own; i++) do_neuron(1);
    finish_ts(1);
    for (int i = 0; i < n_own; i++) do_neuron(2);
    finish_ts(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spe_neuron.md
Name: spe_neuron

Overview:
Clocked spiking processing element (SPE) that sits directly upstream of the output memory (omem).
- Accumulates partial-sum packets from the router for each output neuron it owns.
- In timestep 2, fetches the stored residual potential from omem.
- Applies the threshold and emits a spike/residual store packet to omem.
- One instance per SPE_ID (0..4). Each instance owns neuron indices SPE_ID, SPE_ID+5, SPE_ID+10, ... below OUTPUT_SIZE².

Parameters:
SPE_ID, 0, SPE index 0..4; selects opcodes and owned neurons
OMEM_ID, 11, router address of omem
OUTPUT_SIZE, 21, output map side; total neurons = 441
NUM_PSUMS, 5, partial sums accumulated per neuron
THRESHOLD, 64, firing threshold (unsigned, SUM_WIDTH bits)
SUM_WIDTH, 13, potential/accumulator width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  router packet valid
in_ready  out  1  block accepts in_packet this cycle
in_packet  in  33  [32:29] dest, [28:25] opcode, [24:0] data
out_valid  out  1  outgoing packet valid
out_ready  in  1  router accepts out_packet
out_packet  out  33  same format as in_packet
ts_o  out  2  current timestep (1 or 2)
done_o  out  1  all neurons of both timesteps processed
sat_o  out  1  sticky: an accumulation saturated

Behaviour:
Clock and reset:
- Single clock domain clk.
- reset is synchronous and active-high.
- Reset values: in_ready=0, out_valid=0, out_packet=0, ts_o=1, done_o=0, sat_o=0, state=ACCUM, acc=0, psum_cnt=0, neuron_idx=SPE_ID.

Handshakes:
- A transfer occurs on a clk edge where valid&&ready.
- out_packet and out_valid hold stable until accepted.
- in_ready is a combinational function of state and in_packet opcode.
- A packet whose opcode is not expected in the current state is stalled (in_ready=0), never dropped.

Input opcodes at the SPE:
- 2 = partial sum; data[SUM_WIDTH-1:0] unsigned.
- 0 = residual response; data[SUM_WIDTH-1:0].
- 15 = timestep done; data ignored.

States:
ACCUM:
- in_ready = (opcode==2).
- On each accept: acc = sat(acc + psum) and psum_cnt++.
- sat clamps to 2^SUM_WIDTH-1 and sets sat_o.
- After the NUM_PSUMS-th accept: ts1 -> FIRE; ts2 -> REQ.

REQ:
- out_packet = {OMEM_ID, 2*SPE_ID+1, 25'd0}, out_valid=1.
- On accept -> WAIT_RES.

WAIT_RES:
- in_ready = (opcode==0).
- On accept: acc = sat(acc + residual) -> FIRE.

FIRE (one cycle):
- spike = (acc >= THRESHOLD).
- pot = spike ? acc-THRESHOLD : acc.
- out_packet = {OMEM_ID, 2*SPE_ID, zero-extended pot in [24:1], spike in [0]} -> SEND.

SEND:
- out_valid=1.
- On accept: acc=0, psum_cnt=0, neuron_idx += 5.
- If new neuron_idx >= 441: ts1 -> WAIT_TS; ts2 -> DONE. Otherwise -> ACCUM.

WAIT_TS:
- in_ready = (opcode==15).
- On accept: ts_o=2, neuron_idx=SPE_ID -> ACCUM.

DONE:
- done_o=1, in_ready=0, out_valid=0.
- Held until reset.

Latency:
- Last psum accept to store packet valid: 2 cycles in ts1.
- In ts2, store packet valid 2 cycles after residual accept.

Neuron counts:
- SPE 0 fires 89 neurons per timestep; SPEs 1..4 fire 88 each.

Boundary conditions:
- Reset asserted mid-packet (out_valid high) drops the packet immediately; out_valid=0 on the next edge.
- Any out_ready pattern is allowed; at most one outgoing packet is in flight.
- THRESHOLD=0: every neuron spikes and pot=acc.

Decomposition:
Shared package snn_pkt_pkg holds:
- packet field positions (ADDR 32:29, OPCODE 28:25, DATA 24:0);
- opcode constants: OP_SPE_SEND(id)=2*id, OP_SPE_REQ(id)=2*id+1, OP_PSUM=2, OP_RESIDUAL=0, OP_TIMESTEP_DONE=15;
- SUM_WIDTH;
- state enum type.

Sub-module spe_sat_add: SUM_WIDTH-bit unsigned saturating adder with a saturation flag, reused for psum and residual accumulation.

Test Plan:
1. SPE_ID=2, ts1, psums 10,20,5,15,20 (sum 70) -> out_packet dest 11, opcode 4, data 13 (pot 6, spike 1), out_valid 2 cycles after last psum.
2. ts1, psums 6 each (sum 30) -> data 60 (pot 30, spike 0). After all 88 neurons -> WAIT_TS; opcode 15 -> ts_o=2.
3. ts2, psums summing to 40 -> REQ packet {11, opcode 5, 0}. Residual 30 returned -> data 13 (pot 70-64=6, spike 1).
4. Five psums of 8000 -> acc saturates to 8191 and sat_o=1 -> pot 8127, spike 1.
5. out_ready low for 10 cycles during SEND -> out_packet stable, out_valid held, no new psum accepted. A psum presented in WAIT_RES is stalled (in_ready=0) until the residual arrives.
6. reset pulsed during WAIT_RES -> next cycle ts_o=1, out_valid=0, done_o=0, neuron_idx=SPE_ID. A full two-timestep run afterwards ends with done_o=1 after 89 (SPE 0) or 88 store packets per timestep.
